pipeline_ctrl_sequencer: RTL and testbench



---
 rtl/pipeline_ctrl_sequencer_pkg.sv | 14 +
 rtl/pipeline_ctrl_sequencer_hazard_detect_lu.sv | 16 +
 rtl/pipeline_ctrl_sequencer_sat_cnt.sv | 19 +
 rtl/pipeline_ctrl_sequencer.sv | 99 +++++++++
 tb/tb_pipeline_ctrl_sequencer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_sequencer_pkg.sv
// rtl/pipeline_ctrl_sequencer_pkg.sv - shared state encodings and widths for the pipeline sequencer
package pipeline_ctrl_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HALT = 2'b01,
        ST_STEP = 2'b10,
        ST_END  = 2'b11
    } seq_state_t;

    localparam int NB_REG_DEFAULT = 5;
    localparam int NB_CNT_DEFAULT = 32;

endpackage

// File: rtl/pipeline_ctrl_sequencer_hazard_detect_lu.sv
// rtl/pipeline_ctrl_sequencer_hazard_detect_lu.sv - load-use hazard detection between ID/EX and IF/ID
module hazard_detect_lu #(
    parameter int NB_REG = 5
) (
    input  logic              id_ex_mem_rd,
    input  logic [NB_REG-1:0] id_ex_rt,
    input  logic [NB_REG-1:0] if_id_rs,
    input  logic [NB_REG-1:0] if_id_rt,
    output logic              lu
);

    // $zero is never a real dependency, so a load into r0 never stalls
    assign lu = id_ex_mem_rd && (id_ex_rt != '0) &&
                ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

endmodule

// File: rtl/pipeline_ctrl_sequencer_sat_cnt.sv
// rtl/pipeline_ctrl_sequencer_sat_cnt.sv - saturating up-counter for cycle and stall statistics
module sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl_sequencer.sv
// rtl/pipeline_ctrl_sequencer.sv - stall/flush/freeze sequencer and debug execution FSM for the 5-stage pipeline
module pipeline_ctrl_sequencer
    import pipeline_ctrl_sequencer_pkg::*;
#(
    parameter int NB_REG    = NB_REG_DEFAULT,
    parameter int NB_CNT    = NB_CNT_DEFAULT,
    parameter int START_RUN = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_id_ex_mem_rd,
    input  logic [NB_REG-1:0] i_id_ex_rt,
    input  logic [NB_REG-1:0] i_if_id_rs,
    input  logic [NB_REG-1:0] i_if_id_rt,
    input  logic              i_branch_taken,
    input  logic              i_wb_halt,
    input  logic              i_dbg_run,
    input  logic              i_dbg_halt,
    input  logic              i_dbg_step,
    output logic              o_pc_en,
    output logic              o_if_id_en,
    output logic              o_if_id_flush,
    output logic              o_id_ex_en,
    output logic              o_id_ex_bubble,
    output logic              o_ex_mem_en,
    output logic              o_mem_wb_en,
    output logic              o_step_done,
    output logic              o_halted,
    output logic              o_end,
    output logic [NB_CNT-1:0] o_cycle_cnt,
    output logic [NB_CNT-1:0] o_stall_cnt
);

    seq_state_t state;
    logic       lu;
    logic       active;
    logic       stall;

    hazard_detect_lu #(.NB_REG(NB_REG)) u_hazard (
        .id_ex_mem_rd (i_id_ex_mem_rd),
        .id_ex_rt     (i_id_ex_rt),
        .if_id_rs     (i_if_id_rs),
        .if_id_rt     (i_if_id_rt),
        .lu           (lu)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= (START_RUN != 0) ? ST_RUN : ST_HALT;
            o_step_done <= 1'b0;
        end else begin
            o_step_done <= (state == ST_STEP);
            case (state)
                ST_RUN: begin
                    if (i_wb_halt)       state <= ST_END;
                    else if (i_dbg_halt) state <= ST_HALT;
                end
                ST_HALT: begin
                    // a simultaneous halt request cancels run/step
                    if (!i_dbg_halt) begin
                        if (i_dbg_run)       state <= ST_RUN;
                        else if (i_dbg_step) state <= ST_STEP;
                    end
                end
                ST_STEP: state <= i_wb_halt ? ST_END : ST_HALT;
                ST_END:  state <= ST_END;
                default: state <= ST_HALT;
            endcase
        end
    end

    // freeze dominates the load-use stall, which in turn suppresses a branch flush
    assign active         = !i_rst && ((state == ST_RUN) || (state == ST_STEP));
    assign stall          = active && lu;
    assign o_pc_en        = active && !lu;
    assign o_if_id_en     = active && !lu;
    assign o_if_id_flush  = active && !lu && i_branch_taken;
    assign o_id_ex_en     = active;
    assign o_id_ex_bubble = stall;
    assign o_ex_mem_en    = active;
    assign o_mem_wb_en    = active;
    assign o_halted       = (state == ST_HALT);
    assign o_end          = (state == ST_END);

    sat_cnt #(.W(NB_CNT)) u_cycle_cnt (
        .clk (i_clk),
        .rst (i_rst),
        .inc (active),
        .cnt (o_cycle_cnt)
    );

    sat_cnt #(.W(NB_CNT)) u_stall_cnt (
        .clk (i_clk),
        .rst (i_rst),
        .inc (stall),
        .cnt (o_stall_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl_sequencer.sv
// tb/tb_pipeline_ctrl_sequencer.sv - directed table, corner sequences and randomized model check for the sequencer
module tb_pipeline_ctrl_sequencer;

    localparam int NB_REG = 5;
    localparam int NB_CNT = 4;
    localparam int CMAX   = (1 << NB_CNT) - 1;
    localparam int M_RUN  = 0;
    localparam int M_HALT = 1;
    localparam int M_STEP = 2;
    localparam int M_END  = 3;

    localparam logic [6:0] EN_0 = 7'b0000000;
    localparam logic [6:0] EN_N = 7'b1101011;
    localparam logic [6:0] EN_S = 7'b0001111;
    localparam logic [6:0] EN_F = 7'b1111011;

    typedef struct {
        logic       rst;
        logic       mem_rd;
        logic [4:0] ex_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       br;
        logic       wbh;
        logic       run;
        logic       halt;
        logic       step;
    } in_t;

    typedef struct {
        logic [6:0] en;
        logic       sd;
        logic       halted;
        logic       ended;
        int         cyc;
        int         stall;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_rd;
    logic [NB_REG-1:0] ex_rt, rs, rt;
    logic              br, wbh, run, halt, step;
    logic              pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_en;
    logic              step_done, halted, ended;
    logic [NB_CNT-1:0] cycle_cnt, stall_cnt;

    always #5 clk = ~clk;

    pipeline_ctrl_sequencer #(.NB_REG(NB_REG), .NB_CNT(NB_CNT), .START_RUN(0)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_id_ex_mem_rd (mem_rd),
        .i_id_ex_rt     (ex_rt),
        .i_if_id_rs     (rs),
        .i_if_id_rt     (rt),
        .i_branch_taken (br),
        .i_wb_halt      (wbh),
        .i_dbg_run      (run),
        .i_dbg_halt     (halt),
        .i_dbg_step     (step),
        .o_pc_en        (pc_en),
        .o_if_id_en     (if_id_en),
        .o_if_id_flush  (if_id_flush),
        .o_id_ex_en     (id_ex_en),
        .o_id_ex_bubble (id_ex_bubble),
        .o_ex_mem_en    (ex_mem_en),
        .o_mem_wb_en    (mem_wb_en),
        .o_step_done    (step_done),
        .o_halted       (halted),
        .o_end          (ended),
        .o_cycle_cnt    (cycle_cnt),
        .o_stall_cnt    (stall_cnt)
    );

    int   checks = 0;
    int   errors = 0;
    int   m_mode, m_sd, m_cyc, m_stall;
    in_t  cur;
    vec_t tab[25];

    function automatic in_t mi(input logic r, input logic md, input logic [4:0] xrt,
                               input logic [4:0] s, input logic [4:0] t, input logic b,
                               input logic w, input logic ru, input logic h, input logic st);
        in_t v;
        v.rst = r; v.mem_rd = md; v.ex_rt = xrt; v.rs = s; v.rt = t;
        v.br = b; v.wbh = w; v.run = ru; v.halt = h; v.step = st;
        return v;
    endfunction

    function automatic exp_t me(input logic [6:0] en, input logic sd, input logic h,
                                input logic e_end, input int c, input int s);
        exp_t e;
        e.en = en; e.sd = sd; e.halted = h; e.ended = e_end; e.cyc = c; e.stall = s;
        return e;
    endfunction

    function automatic bit m_lu(input in_t v);
        return v.mem_rd && (v.ex_rt != 0) && ((v.ex_rt == v.rs) || (v.ex_rt == v.rt));
    endfunction

    function automatic bit m_active(input in_t v);
        return !v.rst && ((m_mode == M_RUN) || (m_mode == M_STEP));
    endfunction

    function automatic exp_t model_exp(input in_t v);
        exp_t e;
        e.en = EN_0;
        if (m_active(v)) e.en = m_lu(v) ? EN_S : (v.br ? EN_F : EN_N);
        e.sd     = (m_sd != 0);
        e.halted = (m_mode == M_HALT);
        e.ended  = (m_mode == M_END);
        e.cyc    = m_cyc;
        e.stall  = m_stall;
        return e;
    endfunction

    task automatic model_update(input in_t v);
        if (v.rst) begin
            m_mode = M_HALT; m_sd = 0; m_cyc = 0; m_stall = 0;
        end else begin
            if (m_active(v)) begin
                if (m_cyc < CMAX) m_cyc++;
                if (m_lu(v) && m_stall < CMAX) m_stall++;
            end
            m_sd = (m_mode == M_STEP) ? 1 : 0;
            case (m_mode)
                M_RUN:   if (v.wbh) m_mode = M_END; else if (v.halt) m_mode = M_HALT;
                M_HALT:  if (!v.halt) begin
                             if (v.run) m_mode = M_RUN; else if (v.step) m_mode = M_STEP;
                         end
                M_STEP:  m_mode = v.wbh ? M_END : M_HALT;
                default: m_mode = M_END;
            endcase
        end
    endtask

    task automatic drive(input in_t v);
        rst = v.rst; mem_rd = v.mem_rd; ex_rt = v.ex_rt; rs = v.rs; rt = v.rt;
        br = v.br; wbh = v.wbh; run = v.run; halt = v.halt; step = v.step;
        cur = v;
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_update(cur);
        @(negedge clk);
    endtask

    task automatic chk_int(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp_v);
        end
    endtask

    task automatic check(input string nm, input exp_t e);
        chk_int({nm, ".en"}, int'({pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
                                   ex_mem_en, mem_wb_en}), int'(e.en));
        chk_int({nm, ".step_done"}, int'(step_done), int'(e.sd));
        chk_int({nm, ".halted"}, int'(halted), int'(e.halted));
        chk_int({nm, ".end"}, int'(ended), int'(e.ended));
        chk_int({nm, ".cycle_cnt"}, int'(cycle_cnt), e.cyc);
        chk_int({nm, ".stall_cnt"}, int'(stall_cnt), e.stall);
    endtask

    initial begin
        tab[0]  = '{mi(1,0,0,0,0,0,0,0,0,0), me(EN_0,0,1,0,0,0)};
        tab[1]  = '{mi(0,0,0,0,0,0,0,0,0,0), me(EN_0,0,1,0,0,0)};
        tab[2]  = '{mi(0,0,0,0,0,0,0,0,0,1), me(EN_0,0,1,0,0,0)};
        tab[3]  = '{mi(0,0,0,0,0,0,0,0,0,0), me(EN_N,0,0,0,0,0)};
        tab[4]  = '{mi(0,0,0,0,0,0,0,0,0,0), me(EN_0,1,1,0,1,0)};
        tab[5]  = '{mi(0,0,0,0,0,0,0,1,0,0), me(EN_0,0,1,0,1,0)};
        tab[6]  = '{mi(0,1,3,3,9,0,0,0,0,0), me(EN_S,0,0,0,1,0)};
        tab[7]  = '{mi(0,1,0,0,0,0,0,0,0,0), me(EN_N,0,0,0,2,1)};
        tab[8]  = '{mi(0,1,5,1,5,0,0,0,0,0), me(EN_S,0,0,0,3,1)};
        tab[9]  = '{mi(0,1,7,7,2,1,0,0,0,0), me(EN_S,0,0,0,4,2)};
        tab[10] = '{mi(0,0,0,0,0,1,0,0,0,0), me(EN_F,0,0,0,5,3)};
        tab[11] = '{mi(0,0,4,4,4,0,0,0,0,0), me(EN_N,0,0,0,6,3)};
        tab[12] = '{mi(0,0,0,0,0,0,0,0,1,0), me(EN_N,0,0,0,7,3)};
        tab[13] = '{mi(0,0,0,0,0,0,0,1,1,0), me(EN_0,0,1,0,8,3)};
        tab[14] = '{mi(0,0,0,0,0,0,0,0,0,0), me(EN_0,0,1,0,8,3)};
        tab[15] = '{mi(0,1,2,2,0,0,0,0,0,1), me(EN_0,0,1,0,8,3)};
        tab[16] = '{mi(0,1,2,2,0,0,0,0,0,0), me(EN_S,0,0,0,8,3)};
        tab[17] = '{mi(0,0,0,0,0,0,0,0,0,0), me(EN_0,1,1,0,9,4)};
        tab[18] = '{mi(0,0,0,0,0,0,0,1,0,0), me(EN_0,0,1,0,9,4)};
        tab[19] = '{mi(0,0,0,0,0,0,1,0,0,0), me(EN_N,0,0,0,9,4)};
        tab[20] = '{mi(0,0,0,0,0,0,0,1,0,0), me(EN_0,0,0,1,10,4)};
        tab[21] = '{mi(0,0,0,0,0,0,0,0,0,1), me(EN_0,0,0,1,10,4)};
        tab[22] = '{mi(0,0,0,0,0,0,0,0,1,0), me(EN_0,0,0,1,10,4)};
        tab[23] = '{mi(1,0,0,0,0,0,0,0,0,0), me(EN_0,0,0,1,10,4)};
        tab[24] = '{mi(0,0,0,0,0,0,0,0,0,0), me(EN_0,0,1,0,0,0)};

        drive(mi(1,0,0,0,0,0,0,0,0,0));
        finish_cycle();

        for (int k = 0; k < 25; k++) begin
            drive(tab[k].i);
            #2;
            check($sformatf("tab%0d", k), tab[k].e);
            finish_cycle();
        end

        // counters must stick at all-ones rather than wrap
        drive(mi(1,0,0,0,0,0,0,0,0,0)); finish_cycle();
        drive(mi(0,0,0,0,0,0,0,1,0,0)); finish_cycle();
        for (int k = 0; k < 20; k++) begin
            drive(mi(0,1,1,1,0,0,0,0,0,0));
            finish_cycle();
        end
        drive(mi(0,1,1,1,0,0,0,0,0,0));
        #2;
        chk_int("sat_cycle_cnt", int'(cycle_cnt), 15);
        chk_int("sat_stall_cnt", int'(stall_cnt), 15);
        finish_cycle();
        drive(mi(0,0,0,0,0,0,0,0,0,0));
        #2;
        chk_int("sat_cycle_hold", int'(cycle_cnt), 15);

        // reset landing in the middle of a step swallows the step_done pulse
        finish_cycle();
        drive(mi(1,0,0,0,0,0,0,0,0,0)); finish_cycle();
        drive(mi(0,0,0,0,0,0,0,0,0,1)); finish_cycle();
        drive(mi(1,1,3,3,0,0,0,0,0,0));
        #2;
        chk_int("rst_step_en", int'({pc_en, if_id_en, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_en}), 0);
        finish_cycle();
        drive(mi(0,0,0,0,0,0,0,0,0,0));
        #2;
        chk_int("rst_step_done", int'(step_done), 0);
        chk_int("rst_step_halted", int'(halted), 1);
        chk_int("rst_step_cycle", int'(cycle_cnt), 0);
        finish_cycle();

        for (int n = 0; n < 3000; n++) begin
            in_t v;
            v.rst    = ($urandom_range(0, 49) == 0);
            v.mem_rd = $urandom_range(0, 1) != 0;
            v.ex_rt  = 5'($urandom_range(0, 3));
            v.rs     = 5'($urandom_range(0, 3));
            v.rt     = 5'($urandom_range(0, 3));
            v.br     = ($urandom_range(0, 3) == 0);
            v.wbh    = ($urandom_range(0, 39) == 0);
            v.run    = ($urandom_range(0, 7) == 0);
            v.halt   = ($urandom_range(0, 7) == 0);
            v.step   = ($urandom_range(0, 5) == 0);
            drive(v);
            #2;
            check($sformatf("rnd%0d", n), model_exp(v));
            finish_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
